aes_host_seq: RTL and testbench

- Host-side initiator for the byte-serial AES cipher command interface (cmd/din in; ok/ready/dout out).
- Accepts a 128-bit plaintext and key in parallel, then issues the command sequence: load plaintext (SP), load key (SK), start (ST).
- Collects the 16-byte ciphertext stream and presents it as one 128-bit word with a done pulse.
- Sits between a parallel host/register front end and the aescipher core, replacing hand-driven stimulus.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_byte_ser.sv | 26 ++
 rtl/aes_host_seq.sv | 182 ++++++++++++++++++
 tb/tb_aes_host_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared encodings for the host-side AES command sequencer: cipher command codes,
// block size and the sequencer state enumeration.
package aes_pkg;

    localparam logic [1:0] CMD_ID = 2'b00;
    localparam logic [1:0] CMD_ST = 2'b01;
    localparam logic [1:0] CMD_SK = 2'b10;
    localparam logic [1:0] CMD_SP = 2'b11;

    localparam int BLK_BYTES = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LDP_HDR,
        S_LDP_DAT,
        S_GAP1,
        S_LDK_HDR,
        S_LDK_DAT,
        S_GAP2,
        S_START,
        S_WAIT,
        S_COLLECT
    } state_t;

endpackage

// File: rtl/aes_byte_ser.sv
// 128-bit to byte serializer, least-significant byte first. Shared by the
// plaintext and key load phases; load wins over shift.
module aes_byte_ser (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [127:0] i_data,
    output logic [7:0]   o_byte
);

    logic [127:0] r_sh;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {8'h00, r_sh[127:8]};
        end
    end

    assign o_byte = r_sh[7:0];

endmodule

// File: rtl/aes_host_seq.sv
// Host-side initiator for the byte-serial AES cipher: loads plaintext and key,
// starts the cipher, then gathers the 16 ciphertext bytes into one 128-bit word.
module aes_host_seq
    import aes_pkg::*;
#(
    parameter int GAP_CYC = 2,
    parameter int ST_CYC  = 2,
    parameter int TMO_W   = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_key_reuse,
    input  logic [127:0] i_pt,
    input  logic [127:0] i_key,
    output logic [1:0]   o_cmd,
    output logic [7:0]   o_din,
    input  logic         i_ok,
    input  logic         i_ready,
    input  logic [7:0]   i_dout,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [127:0] o_ct
);

    localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [7:0]       ST_LAST   = 8'(ST_CYC - 1);
    localparam logic [7:0]       BYTE_LAST = 8'(BLK_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [TMO_W-1:0] r_tmo;
    logic [127:0]     r_key;
    logic [127:0]     r_ct_sh;
    logic             r_reuse;
    logic             r_key_loaded;

    logic             w_ser_load;
    logic             w_ser_shift;
    logic [127:0]     w_ser_data;
    logic [7:0]       w_ser_byte;
    logic [127:0]     w_ct_next;

    // Serializer holds plaintext from the start edge; key is reloaded during GAP1.
    assign w_ser_load  = (r_state == S_IDLE) || (r_state == S_GAP1);
    assign w_ser_data  = (r_state == S_IDLE) ? i_pt : r_key;
    assign w_ser_shift = (r_state == S_LDP_HDR) || (r_state == S_LDP_DAT) ||
                         (r_state == S_LDK_HDR) || (r_state == S_LDK_DAT);

    aes_byte_ser u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_ser_load),
        .i_shift (w_ser_shift),
        .i_data  (w_ser_data),
        .o_byte  (w_ser_byte)
    );

    always_comb begin
        w_ct_next = r_ct_sh;
        w_ct_next[{r_cnt[3:0], 3'b000} +: 8] = i_dout;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_key        <= '0;
            r_ct_sh      <= '0;
            r_reuse      <= 1'b0;
            r_key_loaded <= 1'b0;
            o_cmd        <= CMD_ID;
            o_din        <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_ct         <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_cmd <= CMD_ID;
                    o_din <= '0;
                    if (i_start) begin
                        r_key   <= i_key;
                        r_reuse <= i_key_reuse;
                        o_busy  <= 1'b1;
                        o_cmd   <= CMD_SP;
                        r_state <= S_LDP_HDR;
                    end
                end
                S_LDP_HDR, S_LDK_HDR: begin
                    o_din   <= w_ser_byte;
                    r_cnt   <= '0;
                    r_state <= (r_state == S_LDP_HDR) ? S_LDP_DAT : S_LDK_DAT;
                end
                S_LDP_DAT, S_LDK_DAT: begin
                    if (r_cnt == BYTE_LAST) begin
                        if (r_state == S_LDK_DAT) r_key_loaded <= 1'b1;
                        o_cmd   <= CMD_ID;
                        o_din   <= '0;
                        r_cnt   <= '0;
                        r_state <= (r_state == S_LDP_DAT) ? S_GAP1 : S_GAP2;
                    end else begin
                        o_din <= w_ser_byte;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_GAP1, S_GAP2: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_state == S_GAP1 && !(r_reuse && r_key_loaded)) begin
                            o_cmd   <= CMD_SK;
                            r_state <= S_LDK_HDR;
                        end else begin
                            o_cmd   <= CMD_ST;
                            r_tmo   <= '0;
                            r_state <= S_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_START: begin
                    if (r_cnt == ST_LAST) begin
                        o_cmd   <= CMD_ID;
                        r_cnt   <= '0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (i_ready) begin
                        // A byte arriving together with ready is byte 0.
                        r_tmo   <= '0;
                        r_state <= S_COLLECT;
                        if (i_ok) begin
                            r_ct_sh <= w_ct_next;
                            r_cnt   <= 8'd1;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (i_ok) begin
                        r_tmo   <= '0;
                        r_ct_sh <= w_ct_next;
                        if (r_cnt == BYTE_LAST) begin
                            o_ct    <= w_ct_next;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_seq.sv
// Bench for aes_host_seq: directed vector table, reference command-stream model,
// randomized cipher responses with stalls, timeout and mid-operation reset.
module tb_aes_host_seq;

    localparam int G = 2;
    localparam int S = 2;
    localparam logic [1:0] ID = 2'b00, ST = 2'b01, SK = 2'b10, SP = 2'b11;

    logic         clk, rst, start, key_reuse, ok, ready;
    logic [127:0] pt, key, ct;
    logic [7:0]   din, dout;
    logic [1:0]   cmd;
    logic         busy, done, err;

    aes_host_seq #(.GAP_CYC(G), .ST_CYC(S), .TMO_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_key_reuse(key_reuse),
        .i_pt(pt), .i_key(key), .o_cmd(cmd), .o_din(din),
        .i_ok(ok), .i_ready(ready), .i_dout(dout),
        .o_busy(busy), .o_done(done), .o_err(err), .o_ct(ct)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    bit           m_kl;     // model: key loaded since reset
    logic [127:0] m_ct;     // model: last completed ciphertext

    logic [1:0] cap_cmd [1:64];
    logic [7:0] cap_din [1:64];

    typedef struct {
        int         cyc;
        logic [1:0] cmd;
        logic [7:0] din;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue a start, record cmd/din for each following cycle and compare the whole
    // record against a command stream assembled from the phase rules.
    task automatic run_seq(input logic [127:0] p, input logic [127:0] k, input bit reuse,
                           input bit noise, input int stop);
        logic [1:0] e_cmd [1:64];
        logic [7:0] e_din [1:64];
        bit full;
        int len, n, c, bad;
        full = !(reuse && m_kl);
        c = 1;
        e_cmd[c] = SP; e_din[c] = 8'h00; c++;
        for (int i = 0; i < 16; i++) begin e_cmd[c] = SP; e_din[c] = p[8*i +: 8]; c++; end
        for (int i = 0; i < G; i++) begin e_cmd[c] = ID; e_din[c] = 8'h00; c++; end
        if (full) begin
            e_cmd[c] = SK; e_din[c] = 8'h00; c++;
            for (int i = 0; i < 16; i++) begin e_cmd[c] = SK; e_din[c] = k[8*i +: 8]; c++; end
            for (int i = 0; i < G; i++) begin e_cmd[c] = ID; e_din[c] = 8'h00; c++; end
        end
        for (int i = 0; i < S; i++) begin e_cmd[c] = ST; e_din[c] = 8'h00; c++; end
        e_cmd[c] = ID; e_din[c] = 8'h00;
        len = c;
        n = (stop > 0) ? stop : len;

        @(negedge clk);
        start = 1'b1; pt = p; key = k; key_reuse = reuse;
        for (int cy = 1; cy <= n; cy++) begin
            @(negedge clk);
            cap_cmd[cy] = cmd;
            cap_din[cy] = din;
            start = 1'b0; ok = 1'b0;
            if (noise && cy < n) begin
                ok   = 1'($urandom_range(0, 1));
                dout = 8'($urandom);
                if (cy > 1 && cy < n - 1) begin
                    start     = 1'($urandom_range(0, 1));
                    pt        = rnd128();
                    key       = rnd128();
                    key_reuse = 1'($urandom_range(0, 1));
                end
            end
        end

        bad = 0;
        for (int cy = 1; cy <= n; cy++)
            if (bad == 0 && (cap_cmd[cy] !== e_cmd[cy] || cap_din[cy] !== e_din[cy])) bad = cy;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream at cycle %0d: got cmd=%0d din=%0h expected cmd=%0d din=%0h",
                     bad, cap_cmd[bad], cap_din[bad], e_cmd[bad], e_din[bad]);
        end
        if (stop == 0 && full) m_kl = 1'b1;
    endtask

    // Cipher side: raise ready, stream 16 bytes (optionally stalling), check done.
    task automatic respond(input logic [127:0] v, input bit same, input int stall_at,
                           input int stall_len);
        int i;
        bit bad;
        int sa;
        i = 0; bad = 0; sa = stall_at;
        ready = 1'b1; ok = 1'b0;
        if (same) begin ok = 1'b1; dout = v[7:0]; i = 1; end
        @(negedge clk);
        ready = 1'b0;
        if (done || !busy || ct !== m_ct) bad = 1;
        while (i < 16) begin
            if (i > 0 && i - 1 == sa) begin
                ok = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    dout = 8'($urandom);
                    @(negedge clk);
                    if (done || !busy || ct !== m_ct) bad = 1;
                end
                sa = -99;
            end
            ok = 1'b1; dout = v[8*i +: 8];
            @(negedge clk);
            i++;
            if (i < 16 && (done || !busy || ct !== m_ct)) bad = 1;
        end
        ok = 1'b0;
        chk("done_pulse", 128'(done), 128'd1);
        chk("busy_at_done", 128'(busy), 128'd0);
        chk("ct_value", ct, v);
        chk("early_done_or_ct", 128'(bad), 128'd0);
        m_ct = v;
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'd0);
    endtask

    initial begin
        logic [127:0] p1, k1, v;
        int w;

        p1 = 128'h00041214120412000c00131108231919;
        k1 = 128'h2475a2b33475568831e2120013aa5487;
        tbl[0]  = '{1,  SP, 8'h00};
        tbl[1]  = '{2,  SP, 8'h19};
        tbl[2]  = '{17, SP, 8'h00};
        tbl[3]  = '{18, ID, 8'h00};
        tbl[4]  = '{19, ID, 8'h00};
        tbl[5]  = '{20, SK, 8'h00};
        tbl[6]  = '{21, SK, 8'h87};
        tbl[7]  = '{36, SK, 8'h24};
        tbl[8]  = '{37, ID, 8'h00};
        tbl[9]  = '{38, ID, 8'h00};
        tbl[10] = '{39, ST, 8'h00};
        tbl[11] = '{40, ST, 8'h00};
        tbl[12] = '{41, ID, 8'h00};

        rst = 1'b1; start = 1'b0; key_reuse = 1'b0; ok = 1'b0; ready = 1'b0;
        pt = '0; key = '0; dout = '0;
        m_kl = 1'b0; m_ct = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 128'(cmd), 128'(ID));
        chk("rst_din", 128'(din), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_ct", ct, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer load sequence, key_reuse=1 without a loaded key.
        run_seq(p1, k1, 1'b1, 1'b0, 0);
        for (int t = 0; t < 13; t++) begin
            chk($sformatf("tbl_cmd_c%0d", tbl[t].cyc), 128'(cap_cmd[tbl[t].cyc]), 128'(tbl[t].cmd));
            chk($sformatf("tbl_din_c%0d", tbl[t].cyc), 128'(cap_din[tbl[t].cyc]), 128'(tbl[t].din));
        end
        respond(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, -1, 0);

        // Key reuse: no SK phase, first ST on cycle 20.
        run_seq(rnd128(), rnd128(), 1'b1, 1'b0, 0);
        chk("reuse_c19_id", 128'(cap_cmd[19]), 128'(ID));
        chk("reuse_c20_st", 128'(cap_cmd[20]), 128'(ST));
        respond(rnd128(), 1'b0, -1, 0);

        // Stall of 3 cycles after byte 5.
        run_seq(rnd128(), rnd128(), 1'b0, 1'b0, 0);
        respond(rnd128(), 1'b0, 5, 3);

        // ready and ok together.
        run_seq(rnd128(), rnd128(), 1'b1, 1'b0, 0);
        respond(rnd128(), 1'b1, -1, 0);

        for (int r = 0; r < 8; r++) begin
            run_seq(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'b1, 0);
            v = rnd128();
            respond(v, 1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(1, 4));
        end

        // No ready: err after 65535 WAIT cycles.
        run_seq(rnd128(), rnd128(), 1'b1, 1'b0, 0);
        w = 0;
        for (int t = 1; t <= 70000; t++) begin
            @(negedge clk);
            if (err) begin w = t; break; end
        end
        chk("tmo_cycles", 128'(w), 128'd65535);
        chk("tmo_busy", 128'(busy), 128'd0);
        chk("tmo_ct_kept", ct, m_ct);
        @(negedge clk);
        chk("tmo_err_one_cycle", 128'(err), 128'd0);
        run_seq(rnd128(), rnd128(), 1'b0, 1'b0, 0);
        respond(rnd128(), 1'b0, -1, 0);

        // Reset in LDK_DAT idx 7 (cycle 28).
        run_seq(rnd128(), rnd128(), 1'b0, 1'b0, 28);
        rst = 1'b1;
        #1;
        chk("arst_cmd", 128'(cmd), 128'(ID));
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_din", 128'(din), 128'd0);
        chk("arst_ct", ct, 128'd0);
        m_kl = 1'b0; m_ct = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_seq(rnd128(), rnd128(), 1'b1, 1'b0, 0);
        chk("post_rst_sk", 128'(cap_cmd[20]), 128'(SK));
        respond(rnd128(), 1'b0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
